// File: rtl/spi_cmd_master.sv
// spi_cmd_master: converts single host requests into write-address, write-data,
// read-address and read-data SPI frames. For read-data frames the byte returned
// on miso is captured and presented on rsp_data with a one-cycle rsp_valid.
//
// Request handshake: a request transfers on any rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE. req_op/req_data are
// sampled only on that edge, and req_valid seen outside IDLE is ignored.
module spi_cmd_master #(
   parameter  int MEM_DEPTH = 256,
   parameter  int RD_WAIT   = 2,
   localparam int ADDR_SIZE = $clog2(MEM_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [1:0]           req_op,
   input  logic [ADDR_SIZE-1:0] req_data,
   output logic                 ss_n,
   output logic                 mosi,
   input  logic                 miso,
   output logic                 rsp_valid,
   output logic [ADDR_SIZE-1:0] rsp_data,
   output logic                 busy,
   output logic [2:0]           dbg_state
);

   // Command word is {op, payload}; the counter must also cover RD_WAIT (<= 15).
   localparam int W_W = ADDR_SIZE + 2;
   localparam int CW  = $clog2(W_W + 16);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CMD   = 3'd1,
      S_SHIFT = 3'd2,
      S_WAIT  = 3'd3,
      S_RECV  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t               state, state_d;
   logic [CW-1:0]        cnt, cnt_d;
   logic [W_W-1:0]       word, word_d;       // shifted left so the MSB is always the next bit out
   logic                 rd_frame, rd_frame_d;
   logic [ADDR_SIZE-1:0] cap, cap_d;
   logic                 ss_n_d, mosi_d, rsp_valid_d;
   logic [ADDR_SIZE-1:0] rsp_data_d;

   // State register plus all registered outputs, loaded from the combinational next values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         word      <= '0;
         rd_frame  <= 1'b0;
         cap       <= '0;
         ss_n      <= 1'b1;
         mosi      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         word      <= word_d;
         rd_frame  <= rd_frame_d;
         cap       <= cap_d;
         ss_n      <= ss_n_d;
         mosi      <= mosi_d;
         rsp_valid <= rsp_valid_d;
         rsp_data  <= rsp_data_d;
      end
   end

   // Next-state, bit counter and command-word sequencing.
   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      word_d     = word;
      rd_frame_d = rd_frame;
      unique case (state)
         S_IDLE: begin
            if (req_valid) begin
               state_d    = S_CMD;
               word_d     = {req_op, req_data};
               rd_frame_d = (req_op == 2'b11);
               cnt_d      = CW'(W_W - 1);
            end
         end
         S_CMD: begin
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (cnt == '0) begin
               if (rd_frame) begin
                  state_d = S_WAIT;
                  cnt_d   = CW'(RD_WAIT - 1);
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               cnt_d  = cnt - CW'(1);
               word_d = {word[W_W-2:0], 1'b0};
            end
         end
         S_WAIT: begin
            if (cnt == '0) begin
               state_d = S_RECV;
               cnt_d   = CW'(ADDR_SIZE - 1);
            end else begin
               cnt_d = cnt - CW'(1);
            end
         end
         S_RECV: begin
            if (cnt == '0) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt - CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Next values of the registered pin outputs, decoded from the state being entered.
   always_comb begin
      ss_n_d      = 1'b1;
      mosi_d      = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data;
      cap_d       = cap;
      if (state == S_RECV) begin
         cap_d = {cap[ADDR_SIZE-2:0], miso};
      end
      unique case (state_d)
         S_CMD, S_SHIFT: begin
            ss_n_d = 1'b0;
            mosi_d = word_d[W_W-1];
         end
         S_WAIT, S_RECV: begin
            ss_n_d = 1'b0;
         end
         S_DONE: begin
            // Only a frame that ran through RECV produces a response.
            if (state == S_RECV) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = cap_d;
            end
         end
         default: begin
            ss_n_d = 1'b1;
         end
      endcase
   end

   assign req_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_spi_cmd_master.sv
// tb_spi_cmd_master: randomized requests against a RAM-side reference model,
// with an SPI slave model on the pins and a scoreboard that checks every frame
// and every read response as the DUT presents them.
module tb_spi_cmd_master;

   localparam int RD_WAIT  = 2;
   localparam int RECV_LO  = 11 + RD_WAIT;   // first miso sample index within a frame
   localparam int RD_LEN   = 19 + RD_WAIT;   // ss_n-low cycles of a read-data frame

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic [7:0] req_data;
   logic       ss_n;
   logic       mosi;
   logic       miso = 1'b0;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       busy;
   logic [2:0] dbg_state;

   initial forever #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   spi_cmd_master #(.MEM_DEPTH(256), .RD_WAIT(RD_WAIT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_data  (req_data),
      .ss_n      (ss_n),
      .mosi      (mosi),
      .miso      (miso),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int vectors     = 0;
   int miscompares = 0;

   logic [10:0] exp_q[$];      // {issued_while_busy, op, data} per accepted request
   int          acc_q[$];      // cycle in which ss_n must first be low
   logic [7:0]  exp_rsp_q[$];  // expected read-data responses

   // reference RAM-side model, updated at request acceptance
   logic [7:0] ref_mem [256];
   logic [7:0] ref_waddr = 8'h00;
   logic [7:0] ref_raddr = 8'h00;

   // slave model on the pins, updated from decoded frames
   logic [7:0] sl_mem [256];
   logic [7:0] sl_waddr = 8'h00;
   logic [7:0] sl_raddr = 8'h00;
   logic [1:0] sl_op    = 2'b00;
   logic [7:0] sl_data  = 8'h00;

   logic [7:0]  hold_rsp    = 8'h00;
   logic        abort_frame = 1'b0;
   logic [31:0] last_bits   = '0;

   task automatic chk(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
      vectors++;
      if (got_v !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got_v, exp_v, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: got event expected none/other (cycle %0d)", name, cyc);
   endtask

   // ---------------- driver tasks ----------------
   task automatic send(input logic [1:0] op, input logic [7:0] d, input bit jit, output int acc);
      bit waited = 1'b0;
      bit done   = 1'b0;
      acc = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (waited && jit) d = 8'($urandom_range(0, 255));
         req_valid = 1'b1;
         req_op    = op;
         req_data  = d;
         if (req_ready === 1'b1) begin
            unique case (op)
               2'b00: ref_waddr = d;
               2'b01: ref_mem[ref_waddr] = d;
               2'b10: ref_raddr = d;
               default: exp_rsp_q.push_back(ref_mem[ref_raddr]);
            endcase
            exp_q.push_back({waited, op, d});
            acc = cyc + 1;
            acc_q.push_back(acc);
            done = 1'b1;
            @(posedge clk);
         end else begin
            waited = 1'b1;
         end
      end
      if (!done) fail_now("accept_timeout");
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         req_valid = 1'b0;
         req_data  = 8'($urandom_range(0, 255));
      end
   endtask

   task automatic wait_idle;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (busy === 1'b0) return;
      end
      fail_now("idle_timeout");
   endtask

   // ---------------- frame monitor and slave model ----------------
   initial begin
      bit          in_frame = 1'b0;
      int          idx      = 0;
      int          gap      = 100;
      int          cur_acc  = 0;
      int          exp_len;
      logic [10:0] cur      = '0;
      logic [31:0] got      = '0;
      logic [31:0] exp_bits;
      forever begin
         @(negedge clk);
         if (ss_n === 1'b0) begin
            if (!in_frame) begin
               in_frame = 1'b1;
               idx      = 0;
               got      = '0;
               sl_op    = 2'b00;
               if (exp_q.size() == 0) begin
                  fail_now("unexpected_frame");
                  cur     = '0;
                  cur_acc = cyc;
               end else begin
                  cur     = exp_q.pop_front();
                  cur_acc = acc_q.pop_front();
               end
               chk("frame_start_cycle", cyc, cur_acc);
               chk("ss_high_gap_min", 32'(gap >= 2), 1);
               if (cur[10]) chk("b2b_gap", gap, 2);
            end
            got = {got[30:0], mosi};
            if (idx == 2)  sl_op   = got[1:0];
            if (idx == 10) sl_data = got[7:0];
            if (sl_op == 2'b11 && idx >= RECV_LO && idx < RECV_LO + 8)
               miso = sl_mem[sl_raddr][7 - (idx - RECV_LO)];
            else
               miso = 1'($urandom_range(0, 1));
            idx++;
         end else begin
            miso = 1'($urandom_range(0, 1));
            if (in_frame) begin
               in_frame = 1'b0;
               gap      = 1;
               if (abort_frame) begin
                  chk("abort_frame_len", idx, 6);
                  abort_frame = 1'b0;
               end else begin
                  exp_len  = (cur[9:8] == 2'b11) ? RD_LEN : 11;
                  exp_bits = 32'({cur[9], cur[9:8], cur[7:0]}) << (exp_len - 11);
                  chk("frame_len", idx, exp_len);
                  chk("mosi_bits", got, exp_bits);
                  last_bits = got;
                  if (cur[9:8] != 2'b11) chk("rsp_hold", rsp_data, hold_rsp);
                  unique case (sl_op)
                     2'b00: sl_waddr = sl_data;
                     2'b01: sl_mem[sl_waddr] = sl_data;
                     2'b10: sl_raddr = sl_data;
                     default: ;
                  endcase
               end
            end else if (gap < 1000) begin
               gap++;
            end
         end
      end
   end

   // ---------------- response monitor ----------------
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            if (exp_rsp_q.size() == 0) begin
               fail_now("unexpected_rsp_valid");
            end else begin
               e = exp_rsp_q.pop_front();
               chk("rsp_data", rsp_data, e);
               chk("rsp_in_done", {busy, ss_n}, 2'b11);
               hold_rsp = e;
            end
         end
      end
   end

   // ---------------- main sequence and report ----------------
   initial begin
      int acc;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = 8'(i * 7 + 3);
         sl_mem[i]  = 8'(i * 7 + 3);
      end
      rst       = 1'b1;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_data  = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ss_n", ss_n, 1);
      chk("reset_mosi", mosi, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_data", rsp_data, 0);
      chk("reset_req_ready", req_ready, 1);
      chk("reset_busy", busy, 0);
      rst = 1'b0;

      // directed frames with fixed expected bit patterns
      send(2'b00, 8'h3C, 1'b0, acc);
      wait_idle();
      chk("wr_addr_3c_bits", last_bits, 32'h03C);
      send(2'b01, 8'hA5, 1'b0, acc);
      wait_idle();
      chk("wr_data_a5_bits", last_bits, 32'h1A5);
      // acceptance happens in the IDLE cycle before CMD; ready must return 13 cycles later
      chk("ready_period", cyc - acc + 1, 13);
      send(2'b01, 8'h5A, 1'b0, acc);
      send(2'b10, 8'h3C, 1'b0, acc);
      send(2'b11, 8'h00, 1'b0, acc);
      wait_idle();
      chk("rd_data_5a", rsp_data, 8'h5A);

      // request held high with payload changing while the master is busy
      for (int i = 0; i < 6; i++) begin
         send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b1, acc);
      end
      wait_idle();

      // reset during the 5th SHIFT cycle of a read-data frame
      send(2'b11, 8'($urandom_range(0, 255)), 1'b0, acc);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (5) @(negedge clk);
      abort_frame = 1'b1;
      rst         = 1'b1;
      void'(exp_rsp_q.pop_back());
      @(negedge clk);
      chk("abort_ss_n", ss_n, 1);
      chk("abort_rsp_valid", rsp_valid, 0);
      chk("abort_rsp_data", rsp_data, 0);
      chk("abort_busy", busy, 0);
      hold_rsp = 8'h00;
      rst      = 1'b0;
      send(2'b00, 8'h01, 1'b0, acc);
      wait_idle();
      chk("post_reset_wr_addr_bits", last_bits, 32'h001);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), acc);
         idle($urandom_range(0, 3));
      end
      wait_idle();
      repeat (3) @(negedge clk);
      chk("frames_outstanding", exp_q.size(), 0);
      chk("rsp_outstanding", exp_rsp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
